ccff_chain_loader: RTL and testbench

//  Configuration-chain controller for the routing tiles (sb/cb ccff chains).
//  - Accepts bitstream words from the host over a valid/ready stream.
//  - Serialises them onto ccff_head, one bit per prog_clk cycle.
//  - Drives a shift enable that an external clock gate uses to gate the fabric prog_clk.
//  - Optional verify pass: the host resends the same bitstream and the block

---
 rtl/ccff_chain_loader_if.sv | 11 +
 rtl/ccff_chain_loader.sv | 128 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between host and the ccff chain loader.
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (output bs_data, output bs_valid, input bs_ready);
    modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises host bitstream words onto ccff_head,
// gates the fabric prog_clk via cfg_clk_en, and optionally verifies ccff_tail.
module ccff_chain_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    input  logic                 verify,
    input  logic                 abort,
    ccff_chain_loader_if.slave   bs,
    output logic                 ccff_head,
    output logic                 cfg_clk_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     err_idx
);
    localparam int unsigned BL_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] hreg;
    logic [BL_W-1:0]   bits_left;
    logic [CNT_W-1:0]  shift_idx;
    logic              verify_q;
    logic              shift_now;
    logic              room;
    logic              ready;
    logic              accept;

    always_ff @(posedge prog_clk) begin
        if (pReset) state <= IDLE;
        else        state <= state_nx;
    end

    // shift_idx is capped so surplus bits of the final word are never shifted out
    always_comb begin
        shift_now = 1'b0;
        room      = 1'b0;
        ready     = 1'b0;
        accept    = 1'b0;
        state_nx  = state;
        shift_now = (state == LOAD) && (bits_left != '0) &&
                    (shift_idx < CNT_W'(CHAIN_LEN));
        room      = ({1'b0, shift_idx} + (CNT_W+1)'(bits_left)) < (CNT_W+1)'(CHAIN_LEN);
        ready     = (state == LOAD) && room &&
                    ((bits_left == '0) || ((bits_left == BL_W'(1)) && shift_now));
        accept    = ready && bs.bs_valid;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                if (abort)                                  state_nx = IDLE;
                else if (shift_idx == CNT_W'(CHAIN_LEN))    state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bs.bs_ready = ready;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            hreg       <= '0;
            bits_left  <= '0;
            shift_idx  <= '0;
            verify_q   <= 1'b0;
            ccff_head  <= 1'b0;
            cfg_clk_en <= 1'b0;
            mismatch   <= 1'b0;
            err_idx    <= '0;
        end else begin
            cfg_clk_en <= 1'b0;
            if (shift_now && !abort) begin
                ccff_head  <= hreg[0];
                cfg_clk_en <= 1'b1;
            end
            // shift_idx has already advanced past the bit now on the chain head
            if (cfg_clk_en && verify_q && (ccff_tail != ccff_head) && !mismatch) begin
                mismatch <= 1'b1;
                err_idx  <= shift_idx - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        verify_q  <= verify;
                        mismatch  <= 1'b0;
                        err_idx   <= '0;
                        shift_idx <= '0;
                        bits_left <= '0;
                        hreg      <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        hreg      <= '0;
                        bits_left <= '0;
                        shift_idx <= '0;
                    end else begin
                        if (accept) begin
                            hreg      <= bs.bs_data;
                            bits_left <= BL_W'(WORD_W);
                        end else if (shift_now) begin
                            hreg      <= hreg >> 1;
                            bits_left <= bits_left - BL_W'(1);
                        end
                        if (shift_now) shift_idx <= shift_idx + CNT_W'(1);
                    end
                end
                FIN: begin
                    hreg      <= '0;
                    bits_left <= '0;
                end
                default: begin
                    hreg      <= '0;
                    bits_left <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 40-flop and a 37-flop loader share one host and
// one chain model; expectations come from the bitstream itself.
module tb_ccff_chain_loader;
    logic       prog_clk = 1'b0;
    logic       pReset   = 1'b1;
    logic       start    = 1'b0;
    logic       verify   = 1'b0;
    logic       abort    = 1'b0;
    logic       sel      = 1'b0;
    logic       valid    = 1'b0;
    logic [7:0] data     = '0;
    logic [39:0] chain   = '0;
    logic       tail;

    logic       head0, en0, busy0, done0, mm0;
    logic       head1, en1, busy1, done1, mm1;
    logic [5:0] eidx0, eidx1;
    logic       head, en, busy, done, mm, ready;
    logic [5:0] eidx;

    int n_cmp = 0;
    int n_err = 0;

    bit          chain_ok = 1'b0;
    logic [39:0] chain_bits = '0;
    int          chain_bits_len = 0;

    ccff_chain_loader_if #(.WORD_W(8)) bs0 ();
    ccff_chain_loader_if #(.WORD_W(8)) bs1 ();

    assign bs0.bs_data  = data;
    assign bs1.bs_data  = data;
    assign bs0.bs_valid = valid & ~sel;
    assign bs1.bs_valid = valid & sel;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(40), .CNT_W(6)) dut0 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start & ~sel), .verify(verify),
        .abort(abort & ~sel), .bs(bs0), .ccff_head(head0), .cfg_clk_en(en0),
        .ccff_tail(tail), .busy(busy0), .done(done0), .mismatch(mm0), .err_idx(eidx0)
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(37), .CNT_W(6)) dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start & sel), .verify(verify),
        .abort(abort & sel), .bs(bs1), .ccff_head(head1), .cfg_clk_en(en1),
        .ccff_tail(tail), .busy(busy1), .done(done1), .mismatch(mm1), .err_idx(eidx1)
    );

    assign head  = sel ? head1 : head0;
    assign en    = sel ? en1   : en0;
    assign busy  = sel ? busy1 : busy0;
    assign done  = sel ? done1 : done0;
    assign mm    = sel ? mm1   : mm0;
    assign eidx  = sel ? eidx1 : eidx0;
    assign ready = sel ? bs1.bs_ready : bs0.bs_ready;
    assign tail  = sel ? chain[36] : chain[39];

    always #5 prog_clk = ~prog_clk;

    // Fabric chain: shifts in ccff_head on gated prog_clk edges
    always @(posedge prog_clk) if (en) chain <= {chain[38:0], head};

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_pass(input bit s, input bit vfy, input logic [7:0] words[$],
                            input int stall_pct, input int refuse_n, input int abort_at,
                            input bit use_reset, input int busy_start_at, input bit start_abort);
        int          len, need_words, wptr, pulses, gaps, refusals, acc0_cyc, inj, refuse_left, idx_e;
        bit          acc_pending, prev_en, fin, want, mm_e, mm_check;
        logic [39:0] bits;
        len        = s ? 37 : 40;
        need_words = (len + 7) / 8;
        bits       = '0;
        for (int k = 0; k < len; k++) bits[k] = words[k / 8][k % 8];
        mm_e     = 1'b0;
        idx_e    = 0;
        mm_check = !vfy || (chain_ok && chain_bits_len == len);
        if (vfy && mm_check)
            for (int k = 0; k < len; k++)
                if (!mm_e && bits[k] != chain_bits[k]) begin mm_e = 1'b1; idx_e = k; end

        @(negedge prog_clk);
        sel = s; verify = vfy; start = 1'b1; abort = start_abort; valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b0; abort = 1'b0; verify = ~vfy;
        check("start_busy", busy, 1);
        check("start_ready", ready, 1);
        check("start_mm_clear", mm, 0);
        check("start_eidx_clear", eidx, 0);

        wptr = 0; pulses = 0; gaps = 0; refusals = 0; acc0_cyc = -100; inj = -1;
        refuse_left = refuse_n; acc_pending = 0; prev_en = 0; fin = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            start = 1'b0; abort = 1'b0; pReset = 1'b0;
            if (acc_pending) begin wptr++; acc_pending = 1'b0; end
            if (inj >= 0) begin
                if (cyc == inj + 1) begin
                    check("stop_busy", busy, 0);
                    if (use_reset) check("rst_mm", mm, 0);
                end
                check("stop_en", en, 0);
                check("stop_done", done, 0);
                if (cyc == inj + 5) fin = 1'b1;
            end else begin
                if (en) begin
                    if (pulses == 0) check("first_latency", cyc - acc0_cyc, 2);
                    if (pulses < len) check("head_bit", head, bits[pulses]);
                    pulses++;
                end else if (pulses > 0 && pulses < len) gaps++;
                if (done) begin
                    check("done_after_last", prev_en, 1);
                    check("pulse_count", pulses, len);
                    check("gap_cycles", gaps, refusals);
                    check("words_taken", wptr, need_words);
                    if (mm_check) begin
                        check("mismatch", mm, mm_e);
                        check("err_idx", eidx, mm_e ? idx_e : 0);
                    end
                    chain_ok = 1'b1; chain_bits = bits; chain_bits_len = len;
                    fin = 1'b1;
                end
                if (!fin) begin
                    if (en && pulses == abort_at) begin
                        if (use_reset) pReset = 1'b1; else abort = 1'b1;
                        valid = 1'b0; inj = cyc; chain_ok = 1'b0;
                    end else begin
                        if (en && pulses == busy_start_at) begin start = 1'b1; verify = vfy; end
                        if (wptr < words.size()) begin
                            data = words[wptr];
                            want = ($urandom_range(99) >= stall_pct);
                            if (refuse_left > 0 && ready && wptr > 0) want = 1'b0;
                            valid = want;
                            if (ready && !want && wptr > 0) begin
                                refusals++;
                                if (refuse_left > 0) refuse_left--;
                            end
                            acc_pending = want && ready;
                            if (acc_pending && wptr == 0) acc0_cyc = cyc;
                        end else valid = 1'b0;
                    end
                end
            end
            prev_en = en;
            if (!fin) @(negedge prog_clk);
        end
        if (!fin) check("timeout", 0, 1);
        valid = 1'b0; start = 1'b0; abort = 1'b0; pReset = 1'b0;
        @(negedge prog_clk);
        check("after_busy", busy, 0);
        check("after_done", done, 0);
        check("after_en", en, 0);
    endtask

    initial begin
        logic [7:0] w[$];
        logic [7:0] wf[$];
        int         fk;
        bit         s;

        repeat (3) @(negedge prog_clk);
        check("rst_head0", head0, 0);  check("rst_en0", en0, 0);   check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);  check("rst_mm0", mm0, 0);   check("rst_eidx0", eidx0, 0);
        check("rst_ready0", bs0.bs_ready, 0);
        check("rst_head1", head1, 0);  check("rst_en1", en1, 0);   check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);  check("rst_mm1", mm1, 0);   check("rst_eidx1", eidx1, 0);
        check("rst_ready1", bs1.bs_ready, 0);
        pReset = 1'b0;
        @(negedge prog_clk);

        // default load, start coincident with abort in IDLE
        w = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        run_pass(0, 0, w, 0, 0, -1, 0, -1, 1);
        // three refused handshakes mid-stream
        run_pass(0, 0, w, 0, 3, -1, 0, -1, 0);
        // clean verify, then verify with bit 17 flipped
        run_pass(0, 1, w, 0, 0, -1, 0, -1, 0);
        wf = w; wf[2] = wf[2] ^ 8'h02;
        run_pass(0, 0, w, 0, 0, -1, 0, -1, 0);
        run_pass(0, 1, wf, 20, 0, -1, 0, -1, 0);
        check("flip17_mm", mm, 1);
        check("flip17_idx", eidx, 17);
        // verify start after a failed verify clears mismatch; chain now holds wf
        run_pass(0, 1, wf, 0, 0, -1, 0, 25, 0);
        // 37-flop chain: sixth word must never be taken
        w = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'hE7, 8'h99};
        run_pass(1, 0, w, 0, 0, -1, 0, -1, 0);
        run_pass(1, 1, w, 0, 0, -1, 0, -1, 0);
        // abort and reset after 12 shifts, each followed by a normal pass
        w = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        run_pass(0, 0, w, 0, 0, 12, 0, -1, 0);
        run_pass(0, 0, w, 0, 0, -1, 0, -1, 0);
        run_pass(0, 0, w, 0, 0, 12, 1, -1, 0);
        run_pass(0, 0, w, 0, 0, -1, 0, 20, 0);

        for (int it = 0; it < 8; it++) begin
            s = 1'($urandom_range(1));
            w = {};
            for (int k = 0; k < 6; k++) w.push_back(8'($urandom));
            run_pass(s, 0, w, $urandom_range(40), 0, -1, 0, -1, 0);
            wf = w;
            if ($urandom_range(1) == 1) begin
                fk = $urandom_range(s ? 36 : 39);
                wf[fk / 8] = wf[fk / 8] ^ 8'(1 << (fk % 8));
            end
            run_pass(s, 1, wf, $urandom_range(40), 0, -1, 0, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
